// File: rtl/fifo_pkg.sv
// Shared FIFO-side definitions: serve-state encoding and default widths
// used by the fifo and by its write-port arbiter.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERVE0 = 2'b01,
    SERVE1 = 2'b10
  } arb_state_e;

  localparam int FIFO_B    = 8;
  localparam int FIFO_MAXB = 4;

  // Smallest counter width able to count 0..maxb-1 (never below 1 bit).
  function automatic int burst_cw(input int maxb);
    int w;
    w = 1;
    while ((1 << w) < maxb) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Two-requester FIFO write-port bundle; master = arbiter side, slave =
// requesters plus downstream fifo.
interface fifo_wr_arbiter_if
  import fifo_pkg::*;
#(
  parameter int B = FIFO_B
);
  logic         req_0;
  logic         req_1;
  logic [B-1:0] data_0;
  logic [B-1:0] data_1;
  logic         fifo_full;
  logic         gnt_0;
  logic         gnt_1;
  logic         wr_en;
  logic [B-1:0] wr_data;
  logic         busy;

  modport master (
    input  req_0, req_1, data_0, data_1, fifo_full,
    output gnt_0, gnt_1, wr_en, wr_data, busy
  );

  modport slave (
    output req_0, req_1, data_0, data_1, fifo_full,
    input  gnt_0, gnt_1, wr_en, wr_data, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter giving two requesters bursts of up to MAXB words
// into one fifo write port; writes are issued in the same cycle as the grant.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int B    = FIFO_B,
  parameter int MAXB = FIFO_MAXB,
  parameter int CW   = 2
) (
  input  logic              clk,
  input  logic              clr,
  fifo_wr_arbiter_if.master bus
);

  arb_state_e    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          last_srv_reg, last_srv_next;

  logic          req_x;
  logic          other_req;
  logic [B-1:0]  data_x;
  logic          beat;
  logic          at_limit;

  // Select the currently granted requester's view of the bus.
  always_comb begin
    req_x     = 1'b0;
    other_req = 1'b0;
    data_x    = '0;
    unique case (state_reg)
      SERVE0: begin
        req_x     = bus.req_0;
        other_req = bus.req_1;
        data_x    = bus.data_0;
      end
      SERVE1: begin
        req_x     = bus.req_1;
        other_req = bus.req_0;
        data_x    = bus.data_1;
      end
      default: ;
    endcase
  end

  // clr also masks the strobe so nothing reaches the fifo in the reset cycle.
  assign beat     = req_x & ~bus.fifo_full & ~clr;
  assign at_limit = (cnt_reg == CW'(MAXB - 1));

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    last_srv_next = last_srv_reg;
    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (bus.req_0 && bus.req_1) begin
          state_next = last_srv_reg ? SERVE0 : SERVE1;
        end else if (bus.req_0) begin
          state_next = SERVE0;
        end else if (bus.req_1) begin
          state_next = SERVE1;
        end
      end
      SERVE0, SERVE1: begin
        if (!req_x || (beat && at_limit)) begin
          last_srv_next = (state_reg == SERVE1);
          cnt_next      = '0;
          if (other_req) begin
            state_next = (state_reg == SERVE0) ? SERVE1 : SERVE0;
          end else begin
            state_next = IDLE;
          end
        end else if (beat) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      last_srv_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      last_srv_reg <= last_srv_next;
    end
  end

  assign bus.gnt_0   = (state_reg == SERVE0);
  assign bus.gnt_1   = (state_reg == SERVE1);
  assign bus.busy    = (state_reg != IDLE);
  assign bus.wr_en   = beat;
  assign bus.wr_data = beat ? data_x : '0;

  a_one_grant : assert property (@(posedge clk) disable iff (clr)
    !(bus.gnt_0 && bus.gnt_1));
  a_cnt_bound : assert property (@(posedge clk) disable iff (clr)
    cnt_reg <= CW'(MAXB - 1));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Vector-table bench for fifo_wr_arbiter with a write-data scoreboard.
module tb_fifo_wr_arbiter;
  import fifo_pkg::*;

  typedef struct {
    bit         clr;
    bit         req_0;
    bit         req_1;
    logic [7:0] data_0;
    logic [7:0] data_1;
    bit         full;
    bit         exp_gnt_0;
    bit         exp_gnt_1;
    bit         exp_wr;
    logic [7:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  logic [7:0] exp_q[$];

  fifo_wr_arbiter_if #(.B(8)) bus ();

  fifo_wr_arbiter #(.B(8), .MAXB(4), .CW(2)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit c, bit r0, bit r1, logic [7:0] d0, logic [7:0] d1,
                              bit f, bit g0, bit g1, bit w, logic [7:0] ed);
    vec_t v;
    v.clr = c; v.req_0 = r0; v.req_1 = r1; v.data_0 = d0; v.data_1 = d1; v.full = f;
    v.exp_gnt_0 = g0; v.exp_gnt_1 = g1; v.exp_wr = w; v.exp_data = ed;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    clr           = v.clr;
    bus.req_0     = v.req_0;
    bus.req_1     = v.req_1;
    bus.data_0    = v.data_0;
    bus.data_1    = v.data_1;
    bus.fifo_full = v.full;
  endtask

  // Drive one row just after the falling edge, check mid-cycle, advance one clock.
  task automatic apply(input int row, input vec_t v);
    logic [7:0] exp_word;
    drive(v);
    if (v.exp_wr) exp_q.push_back(v.exp_data);
    #1;
    $display("row %0d: clr=%b req=%b%b full=%b gnt=%b%b busy=%b wr_en=%b wr_data=%02h",
             row, v.clr, v.req_1, v.req_0, v.full, bus.gnt_1, bus.gnt_0, bus.busy,
             bus.wr_en, bus.wr_data);
    check("gnt_0", row, 32'(bus.gnt_0), 32'(v.exp_gnt_0));
    check("gnt_1", row, 32'(bus.gnt_1), 32'(v.exp_gnt_1));
    check("busy", row, 32'(bus.busy), 32'(v.exp_gnt_0 | v.exp_gnt_1));
    check("wr_en", row, 32'(bus.wr_en), 32'(v.exp_wr));
    check("wr_data", row, 32'(bus.wr_data), 32'(v.exp_data));
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", row, 32'(bus.wr_data), 32'hFFFF_FFFF);
      end else begin
        exp_word = exp_q.pop_front();
        check("sb_write_data", row, 32'(bus.wr_data), 32'(exp_word));
      end
    end else if (exp_q.size() != 0) begin
      exp_word = exp_q.pop_front();
      check("sb_missing_write", row, 32'(bus.wr_en), 32'd1);
    end
    @(negedge clk);
  endtask

  initial begin
    int cycles;
    bit found;

    // Reset and simultaneous requests, then continuous alternation.
    vecs.push_back(mk(1,1,1,8'h00,8'h00,0, 0,0,0,8'h00));
    vecs.push_back(mk(0,1,1,8'h00,8'h00,0, 0,0,0,8'h00));
    vecs.push_back(mk(0,1,1,8'h11,8'h21,0, 1,0,1,8'h11));
    vecs.push_back(mk(0,1,1,8'h12,8'h22,0, 1,0,1,8'h12));
    vecs.push_back(mk(0,1,1,8'h13,8'h23,0, 1,0,1,8'h13));
    vecs.push_back(mk(0,1,1,8'h14,8'h24,0, 1,0,1,8'h14));
    vecs.push_back(mk(0,1,1,8'h15,8'h21,0, 0,1,1,8'h21));
    vecs.push_back(mk(0,1,1,8'h16,8'h22,0, 0,1,1,8'h22));
    vecs.push_back(mk(0,1,1,8'h17,8'h23,0, 0,1,1,8'h23));
    vecs.push_back(mk(0,1,1,8'h18,8'h24,0, 0,1,1,8'h24));
    vecs.push_back(mk(0,1,1,8'h19,8'h25,0, 1,0,1,8'h19));
    vecs.push_back(mk(0,0,0,8'h1A,8'h26,0, 1,0,0,8'h00));
    vecs.push_back(mk(0,0,0,8'h1B,8'h27,0, 0,0,0,8'h00));
    // Single requester: burst of four, one idle cycle, new burst.
    vecs.push_back(mk(0,1,0,8'hA0,8'h00,0, 0,0,0,8'h00));
    vecs.push_back(mk(0,1,0,8'hA0,8'h00,0, 1,0,1,8'hA0));
    vecs.push_back(mk(0,1,0,8'hA1,8'h00,0, 1,0,1,8'hA1));
    vecs.push_back(mk(0,1,0,8'hA2,8'h00,0, 1,0,1,8'hA2));
    vecs.push_back(mk(0,1,0,8'hA3,8'h00,0, 1,0,1,8'hA3));
    vecs.push_back(mk(0,1,0,8'hA4,8'h00,0, 0,0,0,8'h00));
    vecs.push_back(mk(0,1,0,8'hA4,8'h00,0, 1,0,1,8'hA4));
    vecs.push_back(mk(0,1,0,8'hA5,8'h00,0, 1,0,1,8'hA5));
    vecs.push_back(mk(0,0,0,8'hA6,8'h00,0, 1,0,0,8'h00));
    vecs.push_back(mk(0,0,0,8'hA6,8'h00,0, 0,0,0,8'h00));
    // Stall in SERVE1 after two beats, then two more beats and switch.
    vecs.push_back(mk(0,0,1,8'h00,8'hB0,0, 0,0,0,8'h00));
    vecs.push_back(mk(0,0,1,8'h00,8'hB0,0, 0,1,1,8'hB0));
    vecs.push_back(mk(0,0,1,8'h00,8'hB1,0, 0,1,1,8'hB1));
    vecs.push_back(mk(0,1,1,8'hC0,8'hB2,1, 0,1,0,8'h00));
    vecs.push_back(mk(0,1,1,8'hC0,8'hB2,1, 0,1,0,8'h00));
    vecs.push_back(mk(0,1,1,8'hC0,8'hB2,1, 0,1,0,8'h00));
    vecs.push_back(mk(0,1,1,8'hC0,8'hB2,0, 0,1,1,8'hB2));
    vecs.push_back(mk(0,1,1,8'hC0,8'hB3,0, 0,1,1,8'hB3));
    // Early release by requester 0, then tie after SERVE1 ends goes to 0.
    vecs.push_back(mk(0,1,1,8'hC0,8'hB4,0, 1,0,1,8'hC0));
    vecs.push_back(mk(0,0,1,8'hC1,8'hD0,0, 1,0,0,8'h00));
    vecs.push_back(mk(0,1,1,8'hC1,8'hD0,0, 0,1,1,8'hD0));
    vecs.push_back(mk(0,0,0,8'hC1,8'hD1,0, 0,1,0,8'h00));
    vecs.push_back(mk(0,1,1,8'hC1,8'hD1,0, 0,0,0,8'h00));
    vecs.push_back(mk(0,1,1,8'hC1,8'hD1,0, 1,0,1,8'hC1));
    // clr mid-burst in SERVE1 with cnt=2; following tie goes to requester 0.
    vecs.push_back(mk(0,0,1,8'hC2,8'hE0,0, 1,0,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hC2,8'hE0,0, 0,1,1,8'hE0));
    vecs.push_back(mk(0,0,1,8'hC2,8'hE1,0, 0,1,1,8'hE1));
    vecs.push_back(mk(1,1,1,8'hC2,8'hE2,0, 0,1,0,8'h00));
    vecs.push_back(mk(0,1,1,8'hF0,8'hF8,0, 0,0,0,8'h00));
    vecs.push_back(mk(0,1,1,8'hF0,8'hF8,0, 1,0,1,8'hF0));
    vecs.push_back(mk(0,1,1,8'hF1,8'hF8,0, 1,0,1,8'hF1));
    vecs.push_back(mk(0,1,1,8'hF2,8'hF8,0, 1,0,1,8'hF2));
    vecs.push_back(mk(0,1,1,8'hF3,8'hF8,0, 1,0,1,8'hF3));
    vecs.push_back(mk(0,1,1,8'hF4,8'hF8,0, 0,1,1,8'hF8));
    // Request dropped while stalled: grant released with no write.
    vecs.push_back(mk(0,0,0,8'hF4,8'hF9,1, 0,1,0,8'h00));
    vecs.push_back(mk(0,0,0,8'hF4,8'hF9,0, 0,0,0,8'h00));

    // First reset cycle: outputs undefined before the first edge.
    drive(mk(1,0,0,8'h00,8'h00,0, 0,0,0,8'h00));
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
    check("sb_queue_empty", vecs.size(), 32'(exp_q.size()), 32'd0);

    // Fairness: with both requesting from reset, requester 1's first beat
    // comes right after requester 0's four-beat burst.
    drive(mk(1,0,0,8'h00,8'h00,0, 0,0,0,8'h00));
    @(negedge clk);
    drive(mk(0,1,1,8'h55,8'h66,0, 0,0,0,8'h00));
    cycles = 0;
    found  = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      #1;
      if (bus.gnt_1 === 1'b1 && bus.wr_en === 1'b1) begin
        found = 1'b1;
        $display("fairness: requester 1 first beat at cycle %0d, wr_data=%02h",
                 cycles, bus.wr_data);
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
    check("fair_found", 100, 32'(found), 32'd1);
    check("fair_cycle", 100, 32'(cycles), 32'd5);
    check("fair_data", 100, 32'(bus.wr_data), 32'h66);
    check("fair_gnt_0", 100, 32'(bus.gnt_0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
